// File: rtl/fact_cu.sv
// Control unit for the factorial datapath: sequences counter, multiplier and product register,
// range-checks the operand and runs a watchdog on the number of multiply iterations.
module fact_cu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MAX_N = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic [WIDTH-1:0] n_in,
  input  logic             gt,
  output logic             mux,
  output logic             reg_ld,
  output logic             cnt_en,
  output logic             cnt_ld,
  output logic             done,
  output logic             err,
  output logic             busy,
  output logic [2:0]       state
);

  localparam int unsigned IterW = $clog2(MAX_N + 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StCheck = 3'd2,
    StMult  = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [IterW-1:0] iter_q;
  logic             in_range;
  logic             iter_max;

  assign in_range = (n_in <= WIDTH'(MAX_N));
  assign iter_max = (iter_q == IterW'(MAX_N));
  assign state    = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (go) state_d = in_range ? StLoad : StError;
      StLoad:  state_d = StCheck;
      // A healthy datapath never needs more than MAX_N multiplies.
      StCheck: begin
        if (!gt)          state_d = StDone;
        else if (iter_max) state_d = StError;
        else              state_d = StMult;
      end
      StMult:  state_d = StCheck;
      StDone:  if (!go) state_d = StIdle;
      StError: if (!go) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      iter_q  <= '0;
      mux     <= 1'b0;
      reg_ld  <= 1'b0;
      cnt_en  <= 1'b0;
      cnt_ld  <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == StLoad) begin
        iter_q <= '0;
      end else if (state_q == StMult && !iter_max) begin
        iter_q <= iter_q + IterW'(1);
      end
      mux    <= (state_d == StMult);
      reg_ld <= (state_d == StLoad) || (state_d == StMult);
      cnt_en <= (state_d == StMult);
      cnt_ld <= (state_d == StLoad);
      done   <= (state_d == StDone);
      err    <= (state_d == StError);
      busy   <= (state_d == StLoad) || (state_d == StCheck) || (state_d == StMult);
    end
  end

endmodule

// File: tb/tb_fact_cu.sv
// Randomized bench for fact_cu: a datapath model closes the loop, and each request is
// compared against factorial/latency values computed directly from n.
module tb_fact_cu;
  localparam int unsigned Width = 32;
  localparam int unsigned MaxN  = 12;

  logic             clk = 1'b0;
  logic             rst_n, go, gt;
  logic [Width-1:0] n_in;
  logic             mux, reg_ld, cnt_en, cnt_ld, done, err, busy;
  logic [2:0]       state;

  logic [Width-1:0] dp_cnt, dp_prod;
  logic             force_gt;
  int               n_pass = 0;
  int               n_checks = 0;

  fact_cu #(.WIDTH(Width), .MAX_N(MaxN)) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .go     (go),
    .n_in   (n_in),
    .gt     (gt),
    .mux    (mux),
    .reg_ld (reg_ld),
    .cnt_en (cnt_en),
    .cnt_ld (cnt_ld),
    .done   (done),
    .err    (err),
    .busy   (busy),
    .state  (state)
  );

  always #5 clk = ~clk;

  // Datapath: down-counter, multiplier, mux and product register.
  always @(posedge clk) begin
    if (cnt_ld)      dp_cnt <= n_in;
    else if (cnt_en) dp_cnt <= dp_cnt - 1;
    if (reg_ld)      dp_prod <= mux ? dp_prod * dp_cnt : 32'd1;
  end
  assign gt = force_gt | (dp_cnt > 1);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint unsigned fact(input int unsigned n);
    longint unsigned r = 1;
    for (int unsigned i = 2; i <= n; i++) r = r * i;
    return r;
  endfunction

  function automatic logic [6:0] outs();
    return {mux, reg_ld, cnt_en, cnt_ld, done, err, busy};
  endfunction

  // One request from IDLE; wdog forces GT high, drop_early releases GO mid-computation.
  task automatic do_op(input logic [Width-1:0] n, input bit wdog, input bit drop_early);
    int unsigned eff;
    bit          in_range;
    int          exp_cyc, exp_en, exp_ld;
    int          cyc = 0, n_en = 0, n_ld = 0, n_cld = 0;
    eff      = (n == 0) ? 1 : int'(n);
    in_range = (n <= Width'(MaxN));
    if (!in_range) begin
      exp_cyc = 1; exp_en = 0; exp_ld = 0;
    end else if (wdog) begin
      exp_cyc = 2 * MaxN + 3; exp_en = MaxN; exp_ld = MaxN + 1;
    end else begin
      exp_cyc = 2 * eff + 1; exp_en = eff - 1; exp_ld = eff;
    end
    force_gt = wdog;
    n_in = n;
    go = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      cyc++;
      if (cyc == 1) check("first_state", state, in_range ? 1 : 5);
      if (cyc == 2 && drop_early) go = 1'b0;
      n_en  += int'(cnt_en);
      n_ld  += int'(reg_ld);
      n_cld += int'(cnt_ld);
      if (done || err) break;
    end
    check("latency", cyc, exp_cyc);
    check("cnt_en_pulses", n_en, exp_en);
    check("reg_ld_pulses", n_ld, exp_ld);
    check("cnt_ld_pulses", n_cld, in_range ? 1 : 0);
    check("err_flag", err, !in_range || wdog);
    check("done_flag", done, in_range && !wdog);
    if (in_range && !wdog) check("result", dp_prod, fact(eff));
    if (!drop_early) begin
      step();
      check("flag_hold", {done, err}, in_range && !wdog ? 2'b10 : 2'b01);
      go = 1'b0;
    end
    step();
    check("back_idle_state", state, 0);
    check("back_idle_outs", outs(), 0);
    force_gt = 1'b0;
  endtask

  initial begin
    force_gt = 1'b0;
    rst_n = 1'b0;
    go = 1'b1;
    n_in = 3;
    step();
    step();
    check("reset_state", state, 0);
    check("reset_outs", outs(), 0);
    rst_n = 1'b1;
    do_op(3, 1'b0, 1'b0);

    do_op(5, 1'b0, 1'b0);
    do_op(0, 1'b0, 1'b0);
    do_op(1, 1'b0, 1'b0);
    do_op(12, 1'b0, 1'b0);
    do_op(13, 1'b0, 1'b0);
    do_op(32'hffff_ffff, 1'b0, 1'b0);
    do_op(4, 1'b1, 1'b0);
    do_op(6, 1'b0, 1'b1);

    // Reset lands during the third MULT of n=8.
    n_in = 8;
    go = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("mid_mult_state", state, 3);
    rst_n = 1'b0;
    step();
    check("mid_reset_state", state, 0);
    check("mid_reset_outs", outs(), 0);
    rst_n = 1'b1;
    go = 1'b0;
    step();
    do_op(4, 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      logic [Width-1:0] n;
      n = ($urandom_range(0, 7) == 0) ? Width'($urandom) : Width'($urandom_range(0, 14));
      do_op(n, 1'b0, $urandom_range(0, 1) == 1 && n <= Width'(MaxN));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fact_cu.md
Name: fact_cu

Overview:
Control unit for the factorial datapath. It sequences the down-counter, multiplier, mux and product register to compute N_IN!, and gates the result onto the output buffer. A requester drives GO/N_IN, and the controller returns DONE or ERR. The controller also range-checks the operand against overflow and runs a watchdog on the iteration count.

Parameters:
WIDTH, 32, operand/datapath width; must match the datapath instance.
MAX_N, 12, largest operand whose factorial fits in WIDTH bits (12! < 2^32).

Ports:
CLK      input   1      rising-edge clock shared with datapath
RST_N    input   1      synchronous reset, active-low
GO       input   1      level request; held high by requester until DONE or ERR seen
N_IN     input   WIDTH  operand; same bus that drives datapath INPUT
GT       input   1      from datapath comparator; 1 when counter value > 1
MUX      output  1      datapath mux select: 0 = constant 1, 1 = multiplier product
REG_LD   output  1      product register load enable
CNT_EN   output  1      down-counter decrement enable
CNT_LD   output  1      down-counter load (loads INPUT)
DONE     output  1      result valid; enables datapath output buffer
ERR      output  1      operand out of range or watchdog trip
BUSY     output  1      1 in LOAD, CHECK, MULT
STATE    output  3      debug: current state encoding

Behaviour:
- One clock CLK. Reset is synchronous and active-low on RST_N: when RST_N=0 at a rising edge, the state becomes IDLE and the iteration counter clears. Applies mid-operation; the datapath register contents are then don't-care.
- Moore machine. All outputs decode from the state register only; no GO/GT/N_IN combinational path to outputs.
- Encodings: IDLE=0, LOAD=1, CHECK=2, MULT=3, DONE=4, ERROR=5. Codes 6 and 7 go to IDLE on the next edge.
- Reset/IDLE output values: MUX=0, REG_LD=0, CNT_EN=0, CNT_LD=0, DONE=0, ERR=0, BUSY=0, STATE=0.
- IDLE: GO=1 and N_IN>MAX_N -> ERROR. GO=1 and N_IN<=MAX_N -> LOAD. Otherwise stay in IDLE. Comparison is unsigned, full WIDTH.
- LOAD: CNT_LD=1, REG_LD=1, MUX=0, BUSY=1; clears the iteration counter; -> CHECK. N_IN must be held stable through this cycle (requester obligation).
- CHECK: BUSY=1, no enables. GT=1 -> MULT; GT=0 -> DONE.
- MULT: MUX=1, REG_LD=1, CNT_EN=1, BUSY=1; iteration counter +1; -> CHECK.
- Watchdog: in CHECK, if GT=1 and the iteration counter = MAX_N, go to ERROR instead of MULT (datapath fault). The iteration counter is ceil(log2(MAX_N+1)) bits and never wraps.
- DONE: DONE=1. Stay while GO=1; -> IDLE when GO=0. Minimum one cycle even if GO already dropped.
- ERROR: ERR=1. Stay while GO=1; -> IDLE when GO=0.
- Latency: DONE asserts 2n+1 cycles after the IDLE edge that samples GO=1, with n=max(N_IN,1). The product register then holds n!; 0! and 1! both yield 1.
- GO dropping mid-computation has no effect; the computation completes to DONE.
- A new request is accepted only after a pass through IDLE, so GO must drop and rise again.

Test Plan:
- Reset: RST_N=0 for 2 cycles with GO=1 -> all outputs 0, STATE=0; after release with GO=1, N_IN=3 -> LOAD on the next edge.
- N_IN=5, GO held: sequence LOAD, then CHECK/MULT x4, then CHECK, then DONE. DONE asserts on cycle 11; exactly 4 CNT_EN pulses, 5 REG_LD pulses; DP OUTPUT=120. Drop GO -> IDLE next cycle.
- N_IN=0 and N_IN=1: DONE on cycle 3, zero MULT cycles, OUTPUT=1. N_IN=12: DONE on cycle 25, OUTPUT=479001600.
- N_IN=13: ERR=1 the cycle after GO is sampled, no CNT_LD/REG_LD pulses. ERR holds while GO=1 and clears the cycle after GO=0.
- Watchdog: force GT=1 permanently, N_IN=4 -> 12 MULT cycles, then ERROR; CNT_EN never pulses a 13th time.
- Mid-operation reset: RST_N=0 during the 3rd MULT of N_IN=8 -> IDLE on that edge with enables 0. A subsequent request with N_IN=4 yields OUTPUT=24 on cycle 9.
